// File: rtl/pos_read_controller.sv
// Read sequencer ahead of position pre-processing: fetches per-cell particle counts,
// then sweeps every neighbour address for each home reference particle, phase 0 then phase 1.
module pos_read_controller #(
   parameter int NUM_NEIGHBOR_CELLS = 13,
   parameter int NUM_FILTER         = 7,
   parameter int PARTICLE_ID_WIDTH  = 7
) (
   input  logic                                                 clk,
   input  logic                                                 rst,
   input  logic                                                 start,
   input  logic                                                 pause_in,
   input  logic [(NUM_NEIGHBOR_CELLS+1)*PARTICLE_ID_WIDTH-1:0]  nb_particle_count,
   output logic                                                 phase,
   output logic                                                 reading_particle_num,
   output logic [PARTICLE_ID_WIDTH-1:0]                         ref_id,
   output logic [PARTICLE_ID_WIDTH-1:0]                         particle_id,
   output logic                                                 rd_en,
   output logic                                                 pause_reading,
   output logic [PARTICLE_ID_WIDTH-1:0]                         home_particle_count,
   output logic                                                 busy,
   output logic                                                 done
);

   localparam int W = PARTICLE_ID_WIDTH;
   localparam int CW = (NUM_NEIGHBOR_CELLS + 1) * W;
   localparam logic [W-1:0] ID_ZERO = {W{1'b0}};
   localparam logic [W-1:0] ID_ONE  = {{(W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RD_NUM   = 3'd1,
      S_WAIT_NUM = 3'd2,
      S_SWEEP    = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t         state_q;
   logic           phase_q;
   logic           rd_num_q;
   logic [W-1:0]   ref_id_q;
   logic [W-1:0]   particle_id_q;
   logic           rd_en_q;
   logic           pause_q;
   logic [W-1:0]   home_cnt_q;
   logic [W-1:0]   max0_q;
   logic [W-1:0]   max1_q;
   logic           busy_q;
   logic           done_q;

   logic [W-1:0]   home_cnt_s;
   logic [W-1:0]   max0_d;
   logic [W-1:0]   max1_d;
   logic [W-1:0]   max_phase_s;
   logic           end_of_cell_s;
   logic           last_phase_s;

   function automatic logic [W-1:0] cell_count(input logic [CW-1:0] counts, input int idx);
      return counts[idx*W +: W];
   endfunction

   // Per-phase maximum count, captured while the count words are valid in WAIT_NUM
   always_comb begin
      home_cnt_s = cell_count(nb_particle_count, 0);
      max0_d     = ID_ZERO;
      max1_d     = ID_ZERO;
      for (int i = 0; i <= NUM_NEIGHBOR_CELLS; i++) begin
         if (i < NUM_FILTER) begin
            if (cell_count(nb_particle_count, i) > max0_d) begin
               max0_d = cell_count(nb_particle_count, i);
            end else begin
               max0_d = max0_d;
            end
         end else begin
            if (cell_count(nb_particle_count, i) > max1_d) begin
               max1_d = cell_count(nb_particle_count, i);
            end else begin
               max1_d = max1_d;
            end
         end
      end
   end

   // An empty phase 1 makes the end of phase 0 the end of the reference particle
   assign max_phase_s   = phase_q ? max1_q : max0_q;
   assign end_of_cell_s = (particle_id_q == max_phase_s);
   assign last_phase_s  = phase_q | (max1_q == ID_ZERO);

   // Sequencer state and all registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         phase_q       <= 1'b0;
         rd_num_q      <= 1'b0;
         ref_id_q      <= ID_ZERO;
         particle_id_q <= ID_ZERO;
         rd_en_q       <= 1'b0;
         pause_q       <= 1'b0;
         home_cnt_q    <= ID_ZERO;
         max0_q        <= ID_ZERO;
         max1_q        <= ID_ZERO;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               phase_q  <= 1'b0;
               rd_num_q <= 1'b0;
               rd_en_q  <= 1'b0;
               pause_q  <= 1'b0;
               busy_q   <= 1'b0;
               done_q   <= 1'b0;
               if (start) begin
                  state_q       <= S_RD_NUM;
                  rd_num_q      <= 1'b1;
                  rd_en_q       <= 1'b1;
                  ref_id_q      <= ID_ZERO;
                  particle_id_q <= ID_ZERO;
                  busy_q        <= 1'b1;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_RD_NUM: begin
               state_q  <= S_WAIT_NUM;
               rd_num_q <= 1'b0;
               rd_en_q  <= 1'b0;
               busy_q   <= 1'b1;
            end
            S_WAIT_NUM: begin
               home_cnt_q <= home_cnt_s;
               max0_q     <= max0_d;
               max1_q     <= max1_d;
               phase_q    <= 1'b0;
               if (home_cnt_s == ID_ZERO) begin
                  state_q       <= S_DONE;
                  done_q        <= 1'b1;
                  busy_q        <= 1'b0;
                  rd_en_q       <= 1'b0;
                  ref_id_q      <= home_cnt_s + ID_ONE;
                  particle_id_q <= ID_ZERO;
               end else begin
                  state_q       <= S_SWEEP;
                  rd_en_q       <= 1'b1;
                  ref_id_q      <= ID_ONE;
                  particle_id_q <= ID_ONE;
               end
            end
            S_SWEEP: begin
               // A paused cycle keeps the last issued address; advance resumes from it
               if (pause_in) begin
                  rd_en_q <= 1'b0;
                  pause_q <= 1'b1;
               end else begin
                  rd_en_q <= 1'b1;
                  pause_q <= 1'b0;
                  if (!end_of_cell_s) begin
                     particle_id_q <= particle_id_q + ID_ONE;
                  end else if (!last_phase_s) begin
                     phase_q       <= 1'b1;
                     particle_id_q <= ID_ONE;
                  end else if (ref_id_q == home_cnt_q) begin
                     state_q       <= S_DONE;
                     done_q        <= 1'b1;
                     busy_q        <= 1'b0;
                     rd_en_q       <= 1'b0;
                     phase_q       <= 1'b0;
                     ref_id_q      <= home_cnt_q + ID_ONE;
                     particle_id_q <= ID_ZERO;
                  end else begin
                     phase_q       <= 1'b0;
                     ref_id_q      <= ref_id_q + ID_ONE;
                     particle_id_q <= ID_ONE;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               rd_en_q <= 1'b0;
               pause_q <= 1'b0;
            end
            default: begin
               state_q  <= S_IDLE;
               phase_q  <= 1'b0;
               rd_num_q <= 1'b0;
               rd_en_q  <= 1'b0;
               pause_q  <= 1'b0;
               busy_q   <= 1'b0;
               done_q   <= 1'b0;
            end
         endcase
      end
   end

   assign phase                = phase_q;
   assign reading_particle_num = rd_num_q;
   assign ref_id               = ref_id_q;
   assign particle_id          = particle_id_q;
   assign rd_en                = rd_en_q;
   assign pause_reading        = pause_q;
   assign home_particle_count  = home_cnt_q;
   assign busy                 = busy_q;
   assign done                 = done_q;

endmodule
